// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the core (C) and aux (A) requesters and lane-aligns sub-word ops.
// Optional macro DMEM_RMW_EN: word-write-only memory, SB/SH done as read-modify-write through a WRITE state.
module dmem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [2:0]            c_funct3,
  input  logic [DM_ADDRESS-1:0] c_addr,
  input  logic [DATA_W-1:0]     c_wdata,
  output logic                  c_gnt,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [2:0]            a_funct3,
  input  logic [DM_ADDRESS-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic                  a_gnt,
  output logic                  rsp_valid,
  output logic                  rsp_port,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [31:0]           mem_raddr,
  output logic [31:0]           mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_wr,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, ACCESS, WRITE, ERR, RESP} state_t;

  state_t                state_reg, state_next;
  logic                  port_reg;
  logic                  we_reg;
  logic                  err_reg;
  logic [2:0]            funct3_reg;
  logic [DM_ADDRESS-1:0] addr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [3:0]            starve_cnt_reg;

  logic                  any_req;
  logic                  pick_a;
  logic                  sel_we;
  logic [2:0]            sel_funct3;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_illegal;
  logic [1:0]            ofs;
  logic [3:0]            lane_mask;
  logic [DATA_W-1:0]     wdata_sh;
  logic [DATA_W-1:0]     rd_sh;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b1;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = |a;
      3'b100:  bad = we;
      3'b101:  bad = we | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // C has priority unless A has been passed over STARVE_MAX times in a row.
  assign any_req     = c_req | a_req;
  assign pick_a      = a_req & (~c_req | (starve_cnt_reg == STARVE_LIM));
  assign sel_we      = pick_a ? a_we     : c_we;
  assign sel_funct3  = pick_a ? a_funct3 : c_funct3;
  assign sel_addr    = pick_a ? a_addr   : c_addr;
  assign sel_wdata   = pick_a ? a_wdata  : c_wdata;
  assign sel_illegal = is_illegal(sel_we, sel_funct3, sel_addr[1:0]);

  assign c_gnt = (state_reg == IDLE) & c_req & ~pick_a;
  assign a_gnt = (state_reg == IDLE) & pick_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      port_reg       <= 1'b0;
      we_reg         <= 1'b0;
      err_reg        <= 1'b0;
      funct3_reg     <= 3'b000;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      starve_cnt_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any_req) begin
        port_reg   <= pick_a;
        we_reg     <= sel_we;
        err_reg    <= sel_illegal;
        funct3_reg <= sel_funct3;
        addr_reg   <= sel_addr;
        wdata_reg  <= sel_wdata;
      end
      if (!a_req || a_gnt) begin
        starve_cnt_reg <= 4'd0;
      end else if (c_gnt && starve_cnt_reg != STARVE_LIM) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = sel_illegal ? ERR : ACCESS;
`ifdef DMEM_RMW_EN
      ACCESS:  state_next = (we_reg && funct3_reg != 3'b010) ? WRITE : RESP;
`else
      ACCESS:  state_next = RESP;
`endif
      WRITE:   state_next = RESP;
      ERR:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ofs = addr_reg[1:0];

  always_comb begin
    case (funct3_reg[1:0])
      2'b00:   lane_mask = 4'b0001 << ofs;
      2'b01:   lane_mask = 4'b0011 << ofs;
      default: lane_mask = 4'b1111;
    endcase
  end

  assign wdata_sh  = wdata_reg << {ofs, 3'b000};
  assign rd_sh     = mem_rdata >> {ofs, 3'b000};
  assign mem_raddr = 32'({addr_reg[DM_ADDRESS-1:2], 2'b00});
  assign mem_waddr = mem_raddr;

`ifdef DMEM_RMW_EN
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] merged;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign bit_mask[8*gi +: 8] = {8{lane_mask[gi]}};
  end

  // Fresh store lanes over the word fetched during ACCESS.
  assign merged = (mem_rdata & ~bit_mask) | (wdata_sh & bit_mask);
`endif

  always_comb begin
    mem_wr    = 4'b0000;
    mem_wdata = wdata_sh;
    rsp_rdata = '0;
    case (state_reg)
      ACCESS: begin
        if (we_reg) begin
`ifdef DMEM_RMW_EN
          if (funct3_reg == 3'b010) mem_wr = 4'b1111;
`else
          mem_wr = lane_mask;
`endif
        end
      end
`ifdef DMEM_RMW_EN
      WRITE: begin
        mem_wr    = 4'b1111;
        mem_wdata = merged;
      end
`endif
      RESP: begin
        if (!we_reg && !err_reg) begin
          case (funct3_reg)
            3'b000:  rsp_rdata = {{(DATA_W-8){rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  rsp_rdata = {{(DATA_W-16){rd_sh[15]}}, rd_sh[15:0]};
            3'b100:  rsp_rdata = {{(DATA_W-8){1'b0}}, rd_sh[7:0]};
            3'b101:  rsp_rdata = {{(DATA_W-16){1'b0}}, rd_sh[15:0]};
            default: rsp_rdata = rd_sh;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = (state_reg == RESP) & err_reg;
  assign rsp_port  = port_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed scoreboard bench for dmem_port_arbiter with a registered-read word RAM model.
// Expectations switch to read-modify-write values when DMEM_RMW_EN is defined.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

`ifdef DMEM_RMW_EN
  localparam int SUB_LAT = 3;
`else
  localparam int SUB_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, a_req, a_we;
  logic [2:0]  c_funct3, a_funct3;
  logic [8:0]  c_addr, a_addr;
  logic [31:0] c_wdata, a_wdata;
  logic        c_gnt, a_gnt;
  logic        rsp_valid, rsp_port, rsp_err, busy;
  logic [31:0] rsp_rdata, mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wr;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt),
    .a_req(a_req), .a_we(a_we), .a_funct3(a_funct3), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [128];
  logic [31:0] rd_q;

  always @(posedge clk) begin
    rd_q <= mem[mem_raddr[8:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wr[b]) mem[mem_waddr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end
  assign mem_rdata = rd_q;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic port; logic [31:0] rdata; logic err; int unsigned at; } rsp_t;
  typedef struct { logic [31:0] addr; logic [3:0] wr; logic [31:0] wdata; int unsigned at; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_rsp
    rsp_t e;
    if (rsp_valid) begin
      $display("rsp  port=%0d rdata=%08h err=%0d cyc=%0d", rsp_port, rsp_rdata, rsp_err, cyc);
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_port", 32'(rsp_port), 32'(e.port));
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_cycle", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin : mon_wr
    wr_t w;
    if (mem_wr != 4'b0000) begin
      $display("mwr  addr=%08h wr=%b wdata=%08h cyc=%0d", mem_waddr, mem_wr, mem_wdata, cyc);
      if (wr_q.size() == 0) begin
        check("unexpected_mem_wr", 32'(mem_wr), 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("mem_waddr", mem_waddr, w.addr);
        check("mem_wr", 32'(mem_wr), 32'(w.wr));
        check("mem_wdata", mem_wdata, w.wdata);
        check("mem_wr_cycle", cyc, w.at);
      end
    end
  end

  always @(negedge clk) begin
    if (c_gnt || a_gnt) check("gnt_onehot", 32'(c_gnt & a_gnt), 32'd0);
  end

  // One request; expectations are queued at the grant cycle.
  task automatic issue(input logic port, input logic we, input logic [2:0] f3, input logic [8:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [3:0] exp_wr, input logic [31:0] exp_wdata, input int lat);
    int n;
    @(posedge clk); #1;
    if (port) begin
      a_req = 1'b1; a_we = we; a_funct3 = f3; a_addr = addr; a_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wdata;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(port ? a_gnt : c_gnt) && n < 50);
    if (!(port ? a_gnt : c_gnt)) begin
      check("gnt_timeout", 32'd0, 32'd1);
    end else begin
      $display("req  port=%0d we=%0d f3=%b addr=%03h wdata=%08h cyc=%0d", port, we, f3, addr, wdata, cyc);
      rsp_q.push_back('{port, exp_rdata, exp_err, cyc + 32'(lat)});
      if (exp_wr != 4'b0000)
        wr_q.push_back('{{23'd0, addr[8:2], 2'b00}, exp_wr, exp_wdata, cyc + 32'(lat) - 1});
    end
    @(posedge clk); #1;
    if (port) a_req = 1'b0; else c_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish within 200us");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int n;
    logic [5:0] exp_seq;
    rst_n = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_funct3 = 3'b000; c_addr = '0; c_wdata = '0;
    a_req = 1'b0; a_we = 1'b0; a_funct3 = 3'b000; a_addr = '0; a_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnts", 32'({c_gnt, a_gnt}), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_addrs", mem_raddr | mem_waddr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Word store/load, aux store.
    issue(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 2);
    issue(0, 0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 0, 4'b0000, 32'h0, 2);
    issue(1, 1, 3'b010, 9'h020, 32'hCAFEF00D, 32'h0, 0, 4'b1111, 32'hCAFEF00D, 2);

    // Byte store into top lane, then signed/unsigned sub-word loads.
`ifdef DMEM_RMW_EN
    issue(0, 1, 3'b000, 9'h013, 32'h00000080, 32'h0, 0, 4'b1111, 32'h80ADBEEF, SUB_LAT);
`else
    issue(0, 1, 3'b000, 9'h013, 32'h00000080, 32'h0, 0, 4'b1000, 32'h80000000, SUB_LAT);
`endif
    issue(0, 0, 3'b000, 9'h013, 32'h0, 32'hFFFFFF80, 0, 4'b0000, 32'h0, 2);
    issue(0, 0, 3'b100, 9'h013, 32'h0, 32'h00000080, 0, 4'b0000, 32'h0, 2);
    issue(0, 0, 3'b001, 9'h012, 32'h0, 32'hFFFF80AD, 0, 4'b0000, 32'h0, 2);
    issue(1, 0, 3'b101, 9'h012, 32'h0, 32'h000080AD, 0, 4'b0000, 32'h0, 2);
    issue(0, 0, 3'b010, 9'h010, 32'h0, 32'h80ADBEEF, 0, 4'b0000, 32'h0, 2);

    // Misaligned and illegal ops: error response, no memory write.
    issue(0, 0, 3'b001, 9'h011, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 2);
    issue(0, 0, 3'b011, 9'h010, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 2);
    issue(1, 1, 3'b100, 9'h020, 32'h55, 32'h0, 1, 4'b0000, 32'h0, 2);
    issue(0, 1, 3'b010, 9'h012, 32'h12345678, 32'h0, 1, 4'b0000, 32'h0, 2);

    // Both ports held: A forced after four consecutive C grants.
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b0; c_funct3 = 3'b010; c_addr = 9'h010; c_wdata = '0;
    a_req = 1'b1; a_we = 1'b0; a_funct3 = 3'b010; a_addr = 9'h020; a_wdata = '0;
    exp_seq = 6'b010000;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(c_gnt || a_gnt) && n < 50);
      if (!(c_gnt || a_gnt)) begin
        check("arb_timeout", 32'd0, 32'd1);
        break;
      end
      $display("arb  grant=%0d a_gnt=%0d cyc=%0d", k, a_gnt, cyc);
      check("arb_order", 32'(a_gnt), 32'(exp_seq[k]));
      if (exp_seq[k]) rsp_q.push_back('{1'b1, 32'hCAFEF00D, 1'b0, cyc + 2});
      else            rsp_q.push_back('{1'b0, 32'h80ADBEEF, 1'b0, cyc + 2});
    end
    @(posedge clk); #1;
    c_req = 1'b0; a_req = 1'b0;

    // Reset during the ACCESS cycle of a word store drops it entirely.
    issue(0, 1, 3'b010, 9'h030, 32'h0BADF00D, 32'h0, 0, 4'b1111, 32'h0BADF00D, 2);
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b1; c_funct3 = 3'b010; c_addr = 9'h030; c_wdata = 32'h12345678;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_gnt && n < 50);
    check("rstmid_gnt", 32'(c_gnt), 32'd1);
    $display("req  port=0 we=1 f3=010 addr=030 wdata=12345678 cyc=%0d (reset follows)", cyc);
    @(posedge clk); #1;
    c_req = 1'b0;
    check("rstmid_wr_before", 32'(mem_wr), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_wr_async", 32'(mem_wr), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_idle", 32'(busy), 32'd0);
    issue(0, 0, 3'b010, 9'h030, 32'h0, 32'h0BADF00D, 0, 4'b0000, 32'h0, 2);

    // Halfword store into upper half of a known word.
    issue(0, 1, 3'b010, 9'h000, 32'h11223344, 32'h0, 0, 4'b1111, 32'h11223344, 2);
`ifdef DMEM_RMW_EN
    issue(0, 1, 3'b001, 9'h002, 32'h0000BEEF, 32'h0, 0, 4'b1111, 32'hBEEF3344, SUB_LAT);
`else
    issue(0, 1, 3'b001, 9'h002, 32'h0000BEEF, 32'h0, 0, 4'b1100, 32'hBEEF0000, SUB_LAT);
`endif
    issue(0, 0, 3'b010, 9'h000, 32'h0, 32'hBEEF3344, 0, 4'b0000, 32'h0, 2);

    repeat (6) @(negedge clk);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
